// File: rtl/sdram_cmd_pkg.sv
// Shared command codes, FSM state type and timeout sizing for the UART-to-SDRAM
// command sequencer.
package sdram_cmd_pkg;

    localparam logic [7:0] CmdWrite  = 8'h77;
    localparam logic [7:0] CmdRead   = 8'h72;
    localparam logic [7:0] RespError = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_SEND
    } state_t;

    // One UART byte is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeout_cycles(input int unsigned clock_freq,
                                                   input int unsigned baud_rate,
                                                   input int unsigned timeout_bytes);
        return timeout_bytes * 10 * (clock_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timeout_counter.sv
// Idle-gap counter: counts enabled cycles and pulses o_tc on the Terminal-th one.
// A clear in the same cycle suppresses the pulse and restarts the count.
module timeout_counter #(
    parameter int unsigned Terminal = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int unsigned Width = (Terminal > 1) ? $clog2(Terminal + 1) : 1;
    localparam logic [Width-1:0] LastCount = Width'(Terminal - 1);

    logic [Width-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == LastCount);
    assign o_tc      = i_enable && !i_clear && w_at_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Host command parser: 'w' addr data issues an SDRAM write, 'r' addr issues a read
// whose low data byte is sent back over the UART; anything else answers '?'.
module uart_cmd_sequencer
    import sdram_cmd_pkg::*;
#(
    parameter int unsigned ClockFreq    = 133_000_000,
    parameter int unsigned BaudRate     = 115200,
    parameter int unsigned TimeoutBytes = 4,
    parameter int unsigned AddrWidth    = 22,
    parameter int unsigned DataWidth    = 16
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst_n,
    input  logic                 i_init_done,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_req_valid,
    output logic                 o_req_we,
    output logic [AddrWidth-1:0] o_req_addr,
    output logic [DataWidth-1:0] o_req_wdata,
    input  logic                 i_req_ready,
    input  logic                 i_rd_valid,
    input  logic [DataWidth-1:0] i_rd_data,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int unsigned TimeoutCycles = timeout_cycles(ClockFreq, BaudRate, TimeoutBytes);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_is_write;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_tx_data;
    logic       r_req_valid;
    logic       r_overrun;

    logic w_byte_taken;
    logic w_byte_dropped;
    logic w_load_err;
    logic w_req_fire;
    logic w_collecting;
    logic w_timeout;

    assign w_collecting = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
    assign w_req_fire   = r_req_valid && i_req_ready;

    // Counter only runs while a command is being collected; any accepted byte restarts it.
    timeout_counter #(
        .Terminal (TimeoutCycles)
    ) u_timeout (
        .i_clk    (i_sys_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_byte_taken || !w_collecting),
        .i_enable (w_collecting),
        .o_tc     (w_timeout)
    );

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: combinational block uses blocking '=' and assigns every output a default
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_byte_taken   = 1'b0;
        w_byte_dropped = 1'b0;
        w_load_err     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_rx_valid && i_init_done) begin
                    w_byte_taken = 1'b1;
                    if (i_rx_data == CmdWrite || i_rx_data == CmdRead) begin
                        w_state_next = ST_GET_ADDR;
                    end else begin
                        w_load_err   = 1'b1;
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (i_rx_valid) begin
                    w_byte_taken = 1'b1;
                    w_state_next = r_is_write ? ST_GET_DATA : ST_ISSUE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (i_rx_valid) begin
                    w_byte_taken = 1'b1;
                    w_state_next = ST_ISSUE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_byte_dropped = i_rx_valid;
                if (w_req_fire) begin
                    w_state_next = r_is_write ? ST_IDLE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                w_byte_dropped = i_rx_valid;
                if (i_rd_valid) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_byte_dropped = i_rx_valid;
                if (i_tx_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_write  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_tx_data   <= '0;
            r_req_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_byte_taken) begin
                r_is_write <= (i_rx_data == CmdWrite);
            end
            if (r_state == ST_GET_ADDR && w_byte_taken) begin
                r_addr <= i_rx_data;
            end
            if (r_state == ST_GET_DATA && w_byte_taken) begin
                r_data <= i_rx_data;
            end
            if (w_load_err) begin
                r_tx_data <= RespError;
            end else if (r_state == ST_WAIT_RD && i_rd_valid) begin
                r_tx_data <= i_rd_data[7:0];
            end
            // Rises the cycle after entering ISSUE and holds until the handshake.
            r_req_valid <= (r_state == ST_ISSUE) && !w_req_fire;
            if (w_byte_dropped) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_req_valid = r_req_valid;
    assign o_req_we    = r_is_write;
    assign o_req_addr  = {{(AddrWidth - 8){1'b0}}, r_addr};
    assign o_req_wdata = {{(DataWidth - 8){1'b0}}, r_data};
    assign o_tx_valid  = (r_state == ST_SEND);
    assign o_tx_data   = r_tx_data;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: init gating, write/read flows, error reply,
// command timeout boundary and overrun flag.
module tb_uart_cmd_sequencer;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    // 4 bytes * 10 bits * (1000/100) clocks per bit
    localparam int TO_CYCLES = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b0;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          busy;
    logic          overrun;

    int n_total = 0;
    int n_bad = 0;
    int req_accepts = 0;
    int tx_accepts = 0;
    logic [7:0] last_tx = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(
        .ClockFreq    (1000),
        .BaudRate     (100),
        .TimeoutBytes (4),
        .AddrWidth    (AW),
        .DataWidth    (DW)
    ) dut (
        .i_sys_clk   (clk),
        .i_rst_n     (rst_n),
        .i_init_done (init_done),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_req_valid (req_valid),
        .o_req_we    (req_we),
        .o_req_addr  (req_addr),
        .o_req_wdata (req_wdata),
        .i_req_ready (req_ready),
        .i_rd_valid  (rd_valid),
        .i_rd_data   (rd_data),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    always @(posedge clk) begin
        if (req_valid && req_ready) req_accepts++;
        if (tx_valid && tx_ready) begin
            tx_accepts++;
            last_tx = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: no request within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({req_valid, tx_valid, busy, overrun, req_we} !== 5'b0 || req_addr !== '0
            || req_wdata !== '0 || tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: ctl=%b addr=%h wdata=%h tx=%h want all zero",
                     {req_valid, tx_valid, busy, overrun, req_we}, req_addr, req_wdata, tx_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_gate();
        int acc0 = req_accepts;
        req_ready = 1'b1;
        send_byte(8'h77); send_byte(8'h05); send_byte(8'h0F);
        repeat (4) @(negedge clk);
        n_total++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || req_accepts != acc0) begin
            n_bad++;
            $display("FAIL init_gate: req_valid=%b busy=%b accepts=%0d want 0 0 %0d",
                     req_valid, busy, req_accepts, acc0);
        end
        req_ready = 1'b0;
        init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int acc0 = req_accepts;
        int tx0 = tx_accepts;
        send_byte(8'h77); send_byte(8'h05); send_byte(8'h0F);
        n_total++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_latency1: req_valid=%b want 0 one cycle after last byte", req_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (req_valid !== 1'b1 || req_we !== 1'b1 || req_addr !== 22'd5 || req_wdata !== 16'h000F) begin
                n_bad++;
                $display("FAIL write_hold[%0d]: v=%b we=%b addr=%h wdata=%h want 1 1 000005 000f",
                         i, req_valid, req_we, req_addr, req_wdata);
            end
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (req_accepts - acc0 != 1 || req_valid !== 1'b0 || busy !== 1'b0
            || tx_accepts != tx0 || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL write_done: accepts=%0d v=%b busy=%b tx_valid=%b want 1 0 0 0",
                     req_accepts - acc0, req_valid, busy, tx_valid);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [15:0] word,
                           input logic [7:0] exp_tx, input string name);
        int tx0 = tx_accepts;
        send_byte(8'h72); send_byte(addr);
        wait_req(name);
        n_total++;
        if (req_we !== 1'b0 || req_addr !== {14'd0, addr}) begin
            n_bad++;
            $display("FAIL %s_req: we=%b addr=%h want 0 %h", name, req_we, req_addr, addr);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = word;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_data  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (tx_valid !== 1'b1 || tx_data !== exp_tx) begin
                n_bad++;
                $display("FAIL %s_tx_hold[%0d]: v=%b data=%h want 1 %h", name, i, tx_valid, tx_data, exp_tx);
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (tx_accepts - tx0 != 1 || last_tx !== exp_tx || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_tx_done: count=%0d byte=%h busy=%b want 1 %h 0",
                     name, tx_accepts - tx0, last_tx, busy, exp_tx);
        end
    endtask

    task automatic test_read();
        do_read(8'h05, 16'hDEAD, 8'hAD, "read");
    endtask

    task automatic test_bad_byte();
        int acc0 = req_accepts;
        int tx0 = tx_accepts;
        // A stray read-data strobe in IDLE must not produce a byte.
        rd_valid = 1'b1; rd_data = 16'h0055;
        @(negedge clk);
        rd_valid = 1'b0;
        n_total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_rd: tx_valid=%b busy=%b want 0 0", tx_valid, busy);
        end
        send_byte(8'h41);
        n_total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
            n_bad++;
            $display("FAIL bad_byte_tx: v=%b data=%h want 1 3f", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (tx_accepts - tx0 != 1 || last_tx !== 8'h3F || req_accepts != acc0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_byte_done: tx=%0d byte=%h req=%0d busy=%b want 1 3f 0 0",
                     tx_accepts - tx0, last_tx, req_accepts - acc0, busy);
        end
    endtask

    task automatic test_timeout();
        int acc0 = req_accepts;
        send_byte(8'h72);
        repeat (TO_CYCLES - 1) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: busy=%b want 1 one cycle before expiry", busy);
        end
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || req_valid !== 1'b0 || req_accepts != acc0) begin
            n_bad++;
            $display("FAIL timeout_fire: busy=%b req_valid=%b want 0 0", busy, req_valid);
        end
        do_read(8'h07, 16'h1234, 8'h34, "after_timeout");
    endtask

    task automatic test_overrun();
        int tx0 = tx_accepts;
        n_total++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_pre: overrun=%b want 0", overrun);
        end
        send_byte(8'h72); send_byte(8'h09);
        wait_req("overrun_req");
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        send_byte(8'h55);
        n_total++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: overrun=%b busy=%b want 1 1", overrun, busy);
        end
        rd_valid = 1'b1; rd_data = 16'h00BE;
        @(negedge clk);
        rd_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if (tx_accepts - tx0 != 1 || last_tx !== 8'hBE || overrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_read: tx=%0d byte=%h overrun=%b busy=%b want 1 be 1 0",
                     tx_accepts - tx0, last_tx, overrun, busy);
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_write();
        test_read();
        test_bad_byte();
        test_timeout();
        test_overrun();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
